dtof_two_stage_histogrammer: RTL and testbench

- Single-pixel dToF two-stage histogram engine. It combines the address decoder, the histogram builder/FSM with peak search, and the window arithmetic.
- A coarse histogram of Np-bit timestamps (`roughData`) is built first, and its peak bin is found.
- A fine-resolution window is then derived around that peak. A fine histogram is built over the next acquisition, and its peak bin is reported.
- Sits between the TDC output and the depth-estimation back end.

---
 rtl/dtof_two_stage_histogrammer_if.sv | 30 +++
 rtl/dtof_two_stage_histogrammer.sv | 96 +++++++++
 tb/tb_dtof_two_stage_histogrammer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/dtof_two_stage_histogrammer_if.sv
// dtof_two_stage_histogrammer_if: sample input (wrEn, roughData) and histogram/peak/window outputs
interface dtof_two_stage_histogrammer_if #(
  parameter int Np = 10,
  parameter int Nb = 4,
  parameter int peakMax = 8
);
  logic wrEn;
  logic [Np-1:0] roughData;
  logic [Nb-1:0] data;
  logic [peakMax-1:0] binCounts;
  logic acq_count_finish;
  logic hisNum;
  logic [Nb-1:0] peakCH;
  logic [Nb-1:0] peakFH;
  logic peakDone;
  logic [Np-1:0] THminus;
  logic [Np-1:0] THpositive;
  logic [Np-1:0] delta;
  logic algebraicReady;
  modport master (
    output wrEn, roughData,
    input data, binCounts, acq_count_finish, hisNum, peakCH, peakFH, peakDone,
    input THminus, THpositive, delta, algebraicReady
  );
  modport slave (
    input wrEn, roughData,
    output data, binCounts, acq_count_finish, hisNum, peakCH, peakFH, peakDone,
    output THminus, THpositive, delta, algebraicReady
  );
endinterface

// File: rtl/dtof_two_stage_histogrammer.sv
// dtof_two_stage_histogrammer: coarse/fine dToF histogram engine; clk, res, bus carries samples in and bins/peaks/window out
module dtof_two_stage_histogrammer #(
  parameter int Np = 10,
  parameter int Nb = 4,
  parameter int peakMax = 8,
  parameter int SAMPLES_PER_HIS = 12
) (
  input logic clk,
  input logic res,
  dtof_two_stage_histogrammer_if.slave bus
);
  localparam int NBINS = 2 ** Nb;
  localparam int CW = $clog2(SAMPLES_PER_HIS + 1);
  localparam logic [Np-1:0] DELTA = Np'(1) << (Np - 2 * Nb);
  typedef enum logic [1:0] {COARSE_ACQ, COARSE_PEAK, FINE_ACQ, FINE_PEAK} state_t;
  state_t state_q;
  logic [peakMax-1:0] bins_q [NBINS];
  logic [CW-1:0] cnt_q;
  logic [Nb-1:0] idx_q, arg_q, peak_ch_q, peak_fh_q;
  logic [peakMax-1:0] max_q;
  logic his_q, fin_q, done_q, rdy_q;
  logic acq, in_win, hit, better;
  logic [Np-1:0] th_lo, th_hi, off;
  logic [Nb-1:0] addr;
  logic [peakMax-1:0] peak_cnt;
  always_comb begin
    acq = state_q == COARSE_ACQ || state_q == FINE_ACQ;
    th_lo = rdy_q ? {peak_ch_q, {(Np - Nb){1'b0}}} : '0;
    th_hi = rdy_q ? {peak_ch_q, {(Np - Nb){1'b1}}} : '0;
    in_win = bus.roughData >= th_lo && bus.roughData <= th_hi;
    off = bus.roughData - th_lo;
    addr = his_q ? Nb'(off >> (Np - 2 * Nb)) : Nb'(bus.roughData >> (Np - Nb));
    hit = !his_q || in_win;
    peak_cnt = bins_q[idx_q];
    better = idx_q == '0 || peak_cnt > max_q;
  end
  assign bus.data = acq ? addr : idx_q;
  assign bus.binCounts = acq ? '0 : peak_cnt;
  assign bus.acq_count_finish = fin_q;
  assign bus.hisNum = his_q;
  assign bus.peakCH = peak_ch_q;
  assign bus.peakFH = peak_fh_q;
  assign bus.peakDone = done_q;
  assign bus.THminus = th_lo;
  assign bus.THpositive = th_hi;
  assign bus.delta = rdy_q ? DELTA : '0;
  assign bus.algebraicReady = rdy_q;
  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= COARSE_ACQ;
      for (int i = 0; i < NBINS; i++) bins_q[i] <= '0;
      cnt_q <= '0;
      idx_q <= '0;
      arg_q <= '0;
      max_q <= '0;
      peak_ch_q <= '0;
      peak_fh_q <= '0;
      his_q <= 1'b0;
      fin_q <= 1'b0;
      done_q <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      fin_q <= 1'b0;
      done_q <= 1'b0;
      if (acq) begin
        if (bus.wrEn) begin
          cnt_q <= cnt_q + 1'b1;
          if (hit && bins_q[addr] != '1) bins_q[addr] <= bins_q[addr] + 1'b1;
          if (cnt_q == CW'(SAMPLES_PER_HIS - 1)) begin
            fin_q <= 1'b1;
            idx_q <= '0;
            state_q <= his_q ? FINE_PEAK : COARSE_PEAK;
          end
        end
      end else begin
        idx_q <= idx_q + 1'b1;
        if (better) begin
          max_q <= peak_cnt;
          arg_q <= idx_q;
        end
        if (idx_q == '1) begin
          done_q <= 1'b1;
          cnt_q <= '0;
          for (int i = 0; i < NBINS; i++) bins_q[i] <= '0;
          his_q <= !his_q;
          state_q <= his_q ? COARSE_ACQ : FINE_ACQ;
          if (his_q) peak_fh_q <= better ? idx_q : arg_q;
          else begin
            peak_ch_q <= better ? idx_q : arg_q;
            rdy_q <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_dtof_two_stage_histogrammer.sv
// tb_dtof_two_stage_histogrammer: scoreboard bench for the two-stage histogrammer (normal and 3-bit saturating instance)
module tb_dtof_two_stage_histogrammer;
  logic clk = 1'b0;
  logic res = 1'b1;
  int total = 0;
  int bad = 0;
  typedef int arr_t [12];
  typedef struct {int idx; int cnt; int sat;} exp_t;
  exp_t exp_q [$];
  int mb [16];
  int pch_m = 0;
  bit his_m = 1'b0;
  dtof_two_stage_histogrammer_if #(.Np(10), .Nb(4), .peakMax(8)) bus ();
  dtof_two_stage_histogrammer_if #(.Np(10), .Nb(4), .peakMax(3)) sbus ();
  assign sbus.wrEn = bus.wrEn;
  assign sbus.roughData = bus.roughData;
  dtof_two_stage_histogrammer #(.Np(10), .Nb(4), .peakMax(8), .SAMPLES_PER_HIS(12)) dut (
    .clk(clk), .res(res), .bus(bus)
  );
  dtof_two_stage_histogrammer #(.Np(10), .Nb(4), .peakMax(3), .SAMPLES_PER_HIS(12)) sdut (
    .clk(clk), .res(res), .bus(sbus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, act, exp);
    end
  endtask
  task automatic check_idle_reset();
    chk("rst_peakDone", bus.peakDone, 0);
    chk("rst_fin", bus.acq_count_finish, 0);
    chk("rst_hisNum", bus.hisNum, 0);
    chk("rst_peakCH", bus.peakCH, 0);
    chk("rst_peakFH", bus.peakFH, 0);
    chk("rst_THminus", bus.THminus, 0);
    chk("rst_THpositive", bus.THpositive, 0);
    chk("rst_delta", bus.delta, 0);
    chk("rst_ready", bus.algebraicReady, 0);
    chk("rst_binCounts", bus.binCounts, 0);
  endtask
  task automatic phase(input arr_t s, input bit gaps, input int reset_at);
    int a;
    int best;
    int sbest;
    bit hit;
    exp_t e;
    for (int i = 0; i < 12; i++) begin
      if (gaps && (i % 3 == 1)) begin
        @(negedge clk);
        bus.wrEn = 1'b0;
        bus.roughData = 10'd5;
        #1 chk("gap_fin", bus.acq_count_finish, 0);
      end
      @(negedge clk);
      bus.wrEn = 1'b1;
      bus.roughData = 10'(s[i]);
      hit = 1'b1;
      a = s[i] >> 6;
      if (his_m) begin
        hit = s[i] >= pch_m * 64 && s[i] <= pch_m * 64 + 63;
        a = (s[i] - pch_m * 64) >> 2;
      end
      if (hit) mb[a]++;
      #1;
      if (hit) chk("addr", bus.data, a);
      chk("acq_fin", bus.acq_count_finish, 0);
    end
    best = 0;
    sbest = 0;
    for (int k = 0; k < 16; k++) begin
      exp_q.push_back('{k, (mb[k] > 255) ? 255 : mb[k], (mb[k] > 7) ? 7 : mb[k]});
      if (mb[k] > mb[best]) best = k;
      if (((mb[k] > 7) ? 7 : mb[k]) > ((mb[sbest] > 7) ? 7 : mb[sbest])) sbest = k;
    end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      bus.wrEn = (k == 0);
      bus.roughData = 10'd0;
      #1;
      if (reset_at == k) begin
        chk("rst_at_idx", bus.data, k);
        res = 1'b1;
        @(negedge clk);
        res = 1'b0;
        exp_q.delete();
        foreach (mb[j]) mb[j] = 0;
        pch_m = 0;
        his_m = 1'b0;
        #1 check_idle_reset();
        repeat (20) begin
          @(negedge clk);
          #1 chk("rst_noDone", bus.peakDone, 0);
        end
        return;
      end
      e = exp_q.pop_front();
      chk("scan_idx", bus.data, e.idx);
      chk("scan_cnt", bus.binCounts, e.cnt);
      chk("scan_sat", sbus.binCounts, e.sat);
      chk("scan_fin", bus.acq_count_finish, k == 0);
      chk("scan_noDone", bus.peakDone, 0);
    end
    @(negedge clk);
    bus.wrEn = 1'b0;
    #1 chk("peakDone", bus.peakDone, 1);
    if (his_m) begin
      chk("peakFH", bus.peakFH, best);
      chk("sat_peakFH", sbus.peakFH, sbest);
    end else begin
      pch_m = best;
      chk("peakCH", bus.peakCH, best);
      chk("sat_peakCH", sbus.peakCH, sbest);
    end
    his_m = !his_m;
    chk("hisNum", bus.hisNum, his_m);
    chk("THminus", bus.THminus, pch_m * 64);
    chk("THpositive", bus.THpositive, pch_m * 64 + 63);
    chk("delta", bus.delta, 4);
    chk("ready", bus.algebraicReady, 1);
    foreach (mb[j]) mb[j] = 0;
    @(negedge clk);
    #1 chk("peakDone_pulse", bus.peakDone, 0);
    chk("idle_bin", bus.binCounts, 0);
  endtask
  initial begin
    bus.wrEn = 1'b0;
    bus.roughData = '0;
    foreach (mb[j]) mb[j] = 0;
    repeat (2) @(negedge clk);
    #1 check_idle_reset();
    res = 1'b0;
    phase('{108, 511, 1023, 90, 90, 90, 1023, 700, 90, 90, 90, 90}, 1'b0, -1);
    phase('{50, 50, 102, 102, 32, 33, 50, 128, 50, 128, 50, 128}, 1'b0, -1);
    phase('{330, 200, 330, 200, 330, 200, 330, 200, 330, 200, 330, 200}, 1'b0, -1);
    phase('{200, 200, 200, 200, 200, 200, 200, 200, 200, 200, 200, 200}, 1'b1, -1);
    phase('{600, 600, 600, 600, 600, 600, 600, 600, 600, 600, 600, 600}, 1'b0, 8);
    phase('{260, 260, 260, 260, 260, 260, 260, 260, 260, 260, 260, 260}, 1'b0, -1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
